// File: rtl/anticipator_table.sv
// Loop-anticipation counter table: a pattern-seeded sweep initialises every entry, then
// multi-port registered reads run alongside a two-stage saturating-counter update pipeline.
module anticipator_table #(
    parameter int          ADDR_W   = 12,
    parameter int          RD_PORTS = 4,
    parameter int          CNT_W    = 2,
    parameter logic [3:0]  JMP_NZ   = 4'hC,
    parameter logic [3:0]  JMP_NS   = 4'hD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*CNT_W-1:0]    rd_data,
    output logic                         rd_vld,
    input  logic                         upd_en,
    input  logic [ADDR_W-1:0]            upd_addr,
    input  logic                         upd_taken,
    output logic                         upd_rdy,
    input  logic                         flush,
    output logic                         init_busy,
    output logic                         dbg_state
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int               DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] mem_q [DEPTH];

    state_e                      state_q, state_d;
    logic [ADDR_W-1:0]           idx_q, idx_d;
    logic                        s1_vld_q, s1_vld_d;
    logic [ADDR_W-1:0]           s1_addr_q, s1_addr_d;
    logic                        s1_taken_q, s1_taken_d;
    logic                        s2_vld_q, s2_vld_d;
    logic [ADDR_W-1:0]           s2_addr_q, s2_addr_d;
    logic [CNT_W-1:0]            s2_val_q, s2_val_d;
    logic                        rd_vld_q, rd_vld_d;
    logic [RD_PORTS*CNT_W-1:0]   rd_data_q, rd_data_d;

    logic                        accept;
    logic [CNT_W-1:0]            s1_cur;
    logic [CNT_W-1:0]            s1_new;
    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic [CNT_W-1:0]            wr_data;

    // Seed pattern: loop-capable opcode field with (hi+lo) mod 16 in a small set.
    function automatic logic init_pred(input logic [ADDR_W-1:0] a);
        logic [3:0] hi;
        logic [3:0] op;
        logic [3:0] lo;
        logic [3:0] sum;
        logic       loop;
        logic       hit;
        hi   = a[11:8];
        op   = a[7:4];
        lo   = a[3:0];
        sum  = hi + lo;
        loop = (op[3:2] == 2'b01) || (op[3:2] == 2'b10) || (op == JMP_NZ) || (op == JMP_NS);
        case (sum)
            4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10: hit = 1'b1;
            default:                             hit = 1'b0;
        endcase
        return loop && hit;
    endfunction

    assign init_busy = (state_q == INIT);
    assign upd_rdy   = (state_q == RUN) && !flush;
    assign accept    = upd_en && upd_rdy;
    assign rd_vld    = rd_vld_q;
    assign rd_data   = rd_data_q;
    assign dbg_state = state_q;

    // Stage 2 has not written yet when the next update reads, so bypass it on a hit.
    assign s1_cur = (s2_vld_q && (s2_addr_q == s1_addr_q)) ? s2_val_q : mem_q[s1_addr_q];

    always_comb begin
        s1_new = s1_cur;
        if (s1_taken_q) begin
            if (s1_cur != CNT_MAX) s1_new = s1_cur + CNT_ONE;
        end else begin
            if (s1_cur != '0) s1_new = s1_cur - CNT_ONE;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        s1_vld_d   = 1'b0;
        s1_addr_d  = s1_addr_q;
        s1_taken_d = s1_taken_q;
        s2_vld_d   = 1'b0;
        s2_addr_d  = s2_addr_q;
        s2_val_d   = s2_val_q;
        case (state_q)
            INIT: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == '1) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = INIT;
                    idx_d   = '0;
                end else begin
                    s1_vld_d  = accept;
                    if (accept) begin
                        s1_addr_d  = upd_addr;
                        s1_taken_d = upd_taken;
                    end
                    s2_vld_d  = s1_vld_q;
                    s2_addr_d = s1_addr_q;
                    s2_val_d  = s1_new;
                end
            end
            default: begin
                state_d = INIT;
                idx_d   = '0;
            end
        endcase
    end

    // Single write port shared by the sweep and the update pipeline; a flush drops stage 2.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s2_addr_q;
        wr_data = s2_val_q;
        if (state_q == INIT) begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
            wr_data = init_pred(idx_q) ? CNT_MAX : '0;
        end else if (s2_vld_q && !flush) begin
            wr_en = 1'b1;
        end
    end

    always_comb begin
        rd_vld_d  = (state_q == RUN) && !flush;
        rd_data_d = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            if (rd_vld_d) begin
                rd_data_d[p*CNT_W +: CNT_W] = mem_q[rd_addr[p*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            idx_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_taken_q <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_addr_q  <= '0;
            s2_val_q   <= '0;
            rd_vld_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            s1_vld_q   <= s1_vld_d;
            s1_addr_q  <= s1_addr_d;
            s1_taken_q <= s1_taken_d;
            s2_vld_q   <= s2_vld_d;
            s2_addr_q  <= s2_addr_d;
            s2_val_q   <= s2_val_d;
            rd_vld_q   <= rd_vld_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_anticipator_table.sv
// Self-checking bench for anticipator_table: sweep timing, seeded contents, saturating
// updates with forwarding, read/update ordering, flush and asynchronous reset.
`timescale 1ns/1ps
module tb_anticipator_table;

    localparam int AW = 12;
    localparam int NP = 4;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*CW-1:0]  rd_data;
    logic              rd_vld;
    logic              upd_en;
    logic [AW-1:0]     upd_addr;
    logic              upd_taken;
    logic              upd_rdy;
    logic              flush;
    logic              init_busy;
    logic              dbg_state;

    logic [CW-1:0]     model_q [4096];
    logic [NP*CW-1:0]  exp_q [$];
    int                n_vec = 0;
    int                n_err = 0;

    anticipator_table dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_vld    (rd_vld),
        .upd_en    (upd_en),
        .upd_addr  (upd_addr),
        .upd_taken (upd_taken),
        .upd_rdy   (upd_rdy),
        .flush     (flush),
        .init_busy (init_busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [CW-1:0] init_val(input int a);
        int hi;
        int op;
        int lo;
        int s;
        bit loop;
        hi   = (a >> 8) & 15;
        op   = (a >> 4) & 15;
        lo   = a & 15;
        s    = (hi + lo) % 16;
        loop = (op >= 4 && op <= 11) || op == 12 || op == 13;
        if (loop && (s == 1 || s == 2 || s == 3 || s == 8 || s == 9 || s == 10)) return 2'd3;
        return 2'd0;
    endfunction

    task automatic model_init();
        for (int a = 0; a < 4096; a++) model_q[a] = init_val(a);
    endtask

    function automatic logic [NP*CW-1:0] exp_word(input logic [NP*AW-1:0] a);
        logic [NP*CW-1:0] r;
        logic [AW-1:0]    ad;
        r = '0;
        for (int p = 0; p < NP; p++) begin
            ad = a[p*AW +: AW];
            r[p*CW +: CW] = model_q[ad];
        end
        return r;
    endfunction

    task automatic model_upd(input logic [AW-1:0] a, input logic tk);
        if (tk) begin
            if (model_q[a] != 2'd3) model_q[a] = model_q[a] + 2'd1;
        end else begin
            if (model_q[a] != 2'd0) model_q[a] = model_q[a] - 2'd1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_read(input string name, input logic [NP*AW-1:0] a);
        logic [NP*CW-1:0] e;
        @(negedge clk);
        rd_addr = a;
        exp_q.push_back(exp_word(a));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if ({rd_vld, rd_data} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL %s: got vld=%b data=%h, want vld=1 data=%h", name, rd_vld, rd_data, e);
        end
    endtask

    task automatic do_upd(input logic [AW-1:0] a, input logic tk);
        @(negedge clk);
        upd_en    = 1'b1;
        upd_addr  = a;
        upd_taken = tk;
        n_vec++;
        if (upd_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL upd_rdy: got %b, want 1", upd_rdy);
        end
        model_upd(a, tk);
        @(posedge clk);
    endtask

    task automatic upd_idle(input int n);
        @(negedge clk);
        upd_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Counts edges until init_busy falls; optionally pulses flush and a request mid-sweep.
    task automatic sweep_check(input string name, input int pulse_at);
        int cyc;
        cyc = 0;
        while (cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!init_busy) break;
            if (cyc == pulse_at) begin
                flush     = 1'b1;
                upd_en    = 1'b1;
                upd_addr  = 12'h041;
                upd_taken = 1'b0;
                #1;
                n_vec++;
                if (upd_rdy !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s rdy_in_init: got %b, want 0", name, upd_rdy);
                end
            end else begin
                flush  = 1'b0;
                upd_en = 1'b0;
            end
        end
        n_vec++;
        if (cyc != 4096) begin
            n_err++;
            $display("FAIL %s sweep_len: got %0d cycles, want 4096", name, cyc);
        end
        n_vec++;
        if (upd_rdy !== 1'b1 || dbg_state !== 1'b1) begin
            n_err++;
            $display("FAIL %s rdy_at_run: got rdy=%b state=%b, want 1 1", name, upd_rdy, dbg_state);
        end
    endtask

    task automatic check_cleared(input string name);
        n_vec++;
        if ({init_busy, upd_rdy, rd_vld, rd_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL %s: got busy=%b rdy=%b vld=%b data=%h, want 1 0 0 00",
                     name, init_busy, upd_rdy, rd_vld, rd_data);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; upd_en = 1'b0; upd_addr = '0; upd_taken = 1'b0; rd_addr = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset_state");
        @(negedge clk);
        rst = 1'b1;
        sweep_check("first_sweep", -1);
        model_init();
    endtask

    task automatic test_init_pattern();
        do_read("pattern_038", {12'h0C4, 12'h001, 12'h0C1, 12'h041});
        n_vec++;
        if (rd_data !== 8'h0F) begin
            n_err++;
            $display("FAIL pattern_const: got %h, want 0f", rd_data);
        end
        for (int k = 0; k < 6; k++) begin
            do_read("pattern_rand", {AW'($urandom_range(0, 4095)), AW'($urandom_range(0, 4095)),
                                     AW'($urandom_range(0, 4095)), AW'($urandom_range(0, 4095))});
        end
        do_read("pattern_edges", {12'hFFF, 12'h1A7, 12'hD0A, 12'h000});
    endtask

    task automatic test_saturate();
        repeat (4) do_upd(12'h001, 1'b1);
        upd_idle(3);
        do_read("sat_up", {4{12'h001}});
        n_vec++;
        if (rd_data[1:0] !== 2'd3) begin
            n_err++;
            $display("FAIL sat_up_const: got %0d, want 3", rd_data[1:0]);
        end
        do_upd(12'h041, 1'b0);
        upd_idle(3);
        do_read("dec_once", {4{12'h041}});
        repeat (5) do_upd(12'h041, 1'b0);
        upd_idle(3);
        do_read("sat_down", {12'h041, 12'h0C1, 12'h001, 12'h041});
        n_vec++;
        if (rd_data[1:0] !== 2'd0) begin
            n_err++;
            $display("FAIL sat_down_const: got %0d, want 0", rd_data[1:0]);
        end
    endtask

    task automatic test_same_cycle();
        logic [CW-1:0]    old_v;
        logic [CW-1:0]    new_v;
        logic [NP*CW-1:0] e;
        old_v = model_q[12'h001];
        model_upd(12'h001, 1'b0);
        new_v = model_q[12'h001];
        @(negedge clk);
        upd_en = 1'b1; upd_addr = 12'h001; upd_taken = 1'b0;
        rd_addr = {4{12'h001}};
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back((k < 3) ? {4{old_v}} : {4{new_v}});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({rd_vld, rd_data} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL same_cycle_k%0d: got vld=%b data=%h, want 1 %h", k, rd_vld, rd_data, e);
            end
            @(negedge clk);
            upd_en = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] pool [4];
        logic          en;
        logic [AW-1:0] a;
        logic          tk;
        pool[0] = 12'h001; pool[1] = 12'h041; pool[2] = 12'h0C1; pool[3] = 12'h0C4;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                en = ($urandom_range(0, 4) != 0);
                a  = pool[$urandom_range(0, 3)];
                tk = ($urandom_range(0, 1) == 1);
                upd_en = en; upd_addr = a; upd_taken = tk;
                if (en) model_upd(a, tk);
            end
            upd_idle(3);
            do_read("b2b_burst", {pool[3], pool[2], pool[1], pool[0]});
        end
    endtask

    task automatic test_flush();
        do_upd(12'h0C4, 1'b1);
        do_upd(12'h0C4, 1'b1);
        @(negedge clk);
        upd_en = 1'b0;
        flush  = 1'b1;
        #1;
        n_vec++;
        if (upd_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_rdy: got %b, want 0", upd_rdy);
        end
        @(posedge clk);
        #1;
        check_cleared("flush_enter");
        flush = 1'b0;
        sweep_check("flush_sweep", 100);
        model_init();
        do_read("flush_restore", {12'h0C4, 12'h001, 12'h0C1, 12'h041});
    endtask

    task automatic test_reset_mid();
        do_read("pre_reset", {4{12'h041}});
        #2 rst = 1'b0;
        #1;
        check_cleared("async_run");
        @(negedge clk);
        rst = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_cleared("async_sweep");
        @(negedge clk);
        rst = 1'b1;
        sweep_check("restart_sweep", -1);
        model_init();
        do_read("after_restart", {12'h0C4, 12'h001, 12'h0C1, 12'h041});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_pattern();
        test_saturate();
        test_same_cycle();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
